// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the HCLK-side AHB-to-APB transfer controller.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ENABLE = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR1   = 3'd6,
        ST_ERR2   = 3'd7
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Haddr[31:26] prefixes of the three 64 MB APB slave windows.
    localparam logic [5:0] REGION_S0 = 6'b100000;
    localparam logic [5:0] REGION_S1 = 6'b100001;
    localparam logic [5:0] REGION_S2 = 6'b100010;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

endpackage

// File: rtl/ahb_apb_xfer_ctrl_decode.sv
// Combinational APB slave decode from the top six address bits.
module apb_addr_decode
    import ahb_apb_pkg::*;
(
    input  logic [5:0] region_i,
    output logic [2:0] sel_o,
    output logic       unmapped_o
);

    always_comb begin
        sel_o      = PSEL_NONE;
        unmapped_o = 1'b0;
        case (region_i)
            REGION_S0: sel_o = PSEL_S0;
            REGION_S1: sel_o = PSEL_S1;
            REGION_S2: sel_o = PSEL_S2;
            default:   unmapped_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_apb_xfer_ctrl.sv
// HCLK-domain AHB slave front-end sequencing APB SETUP/ENABLE on the *_hclk lines.
// Define AHB_APB_DECERR_EN to answer unmapped addresses with a two-cycle ERROR response.
module ahb_apb_xfer_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = 4,
    parameter int unsigned RD_SYNC_CYC = 3
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata_hclk,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic        Penable_hclk,
    output logic        Pwrite_hclk,
    output logic [2:0]  Pselx_hclk,
    output logic [31:0] Paddr_hclk,
    output logic [31:0] Pwdata_hclk
);

    localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYC - 1);
    localparam logic [3:0] RDW_LOAD   = (RD_SYNC_CYC == 0) ? 4'd0 : 4'(RD_SYNC_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic [2:0]  dec_sel;
    logic        dec_unmapped;
    logic        valid;

    apb_addr_decode u_decode (
        .region_i   (Haddr[31:26]),
        .sel_o      (dec_sel),
        .unmapped_o (dec_unmapped)
    );

    assign Hreadyout = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign valid     = Hreadyin && Hreadyout && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        sel_d    = sel_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (valid) begin
                    addr_d  = Haddr;
                    write_d = Hwrite;
                    sel_d   = dec_sel;
                    if (!dec_unmapped) begin
                        state_d = ST_LATCH;
                    end else begin
`ifdef AHB_APB_DECERR_EN
                        state_d = ST_ERR1;
`else
                        state_d = ST_DONE;
                        if (!Hwrite) hrdata_d = '0;
`endif
                    end
                end
            end
            ST_LATCH: begin
                if (write_q) pwdata_d = Hwdata;
                cnt_d   = PHASE_LOAD;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = PHASE_LOAD;
                    state_d = ST_ENABLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ENABLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (write_q) begin
                    state_d = ST_DONE;
                end else if (RD_SYNC_CYC == 0) begin
                    hrdata_d = Prdata_hclk;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = RDW_LOAD;
                    state_d = ST_RDWAIT;
                end
            end
            // Give the read data time to cross back through the synchronizer before sampling.
            ST_RDWAIT: begin
                if (cnt_q == 4'd0) begin
                    hrdata_d = Prdata_hclk;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            sel_q    <= PSEL_NONE;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            sel_q    <= sel_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign Hresp        = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign Pselx_hclk   = ((state_q == ST_SETUP) || (state_q == ST_ENABLE)) ? sel_q : PSEL_NONE;
    assign Penable_hclk = (state_q == ST_ENABLE);
    assign Pwrite_hclk  = write_q;
    assign Paddr_hclk   = addr_q;
    assign Pwdata_hclk  = pwdata_q;
    assign Hrdata       = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_xfer_ctrl.sv
// Randomized bench for ahb_apb_xfer_ctrl against a phase-timeline reference model.
module tb_ahb_apb_xfer_ctrl;

    localparam int P = 4;
    localparam int R = 3;

    logic        Hclk = 1'b0;
    logic        Hresetn, Hwrite, Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr, Hwdata, Prdata_hclk;
    logic        Hreadyout, Penable_hclk, Pwrite_hclk;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata, Paddr_hclk, Pwdata_hclk;
    logic [2:0]  Pselx_hclk;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] exp_hrdata, exp_paddr, exp_pwdata;
    logic        exp_pwrite;

    always #5 Hclk = ~Hclk;

    ahb_apb_xfer_ctrl #(.PHASE_CYC(P), .RD_SYNC_CYC(R)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata_hclk(Prdata_hclk),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .Penable_hclk(Penable_hclk), .Pwrite_hclk(Pwrite_hclk), .Pselx_hclk(Pselx_hclk),
        .Paddr_hclk(Paddr_hclk), .Pwdata_hclk(Pwdata_hclk)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [2:0] psel, input logic pen,
                             input logic rdy, input logic [1:0] resp);
        chk({tag, "_psel"}, {29'd0, Pselx_hclk}, {29'd0, psel});
        chk({tag, "_penable"}, {31'd0, Penable_hclk}, {31'd0, pen});
        chk({tag, "_hready"}, {31'd0, Hreadyout}, {31'd0, rdy});
        chk({tag, "_hresp"}, {30'd0, Hresp}, {30'd0, resp});
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_hrdata"}, Hrdata, exp_hrdata);
        chk({tag, "_paddr"}, Paddr_hclk, exp_paddr);
        chk({tag, "_pwdata"}, Pwdata_hclk, exp_pwdata);
        chk({tag, "_pwrite"}, {31'd0, Pwrite_hclk}, {31'd0, exp_pwrite});
    endtask

    function automatic logic [2:0] sel_of(input logic [31:0] addr);
        case (addr[31:26])
            6'd32:   return 3'b001;
            6'd33:   return 3'b010;
            6'd34:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Present a transfer in the current (ready) cycle and follow it to its final ready cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] rdata);
        logic [2:0] sel;
        int last;
        sel = sel_of(addr);
        chk("accept_hready", {31'd0, Hreadyout}, 32'd1);
        Haddr = addr; Hwrite = wr; Htrans = 2'b10; Hreadyin = 1'b1;
        Prdata_hclk = $urandom;
        step();
        Htrans = 2'b00; Haddr = $urandom; Hwrite = 1'($urandom); Hwdata = wdata;
        exp_paddr = addr;
        exp_pwrite = wr;
        if (sel == 3'b000) begin
`ifdef AHB_APB_DECERR_EN
            check_bus("err1", 3'b000, 1'b0, 1'b0, 2'b01);
            step();
            check_bus("err2", 3'b000, 1'b0, 1'b1, 2'b01);
`else
            check_bus("unmapped_done", 3'b000, 1'b0, 1'b1, 2'b00);
            if (!wr) exp_hrdata = 32'd0;
`endif
        end else begin
            last = 1 + 2 * P + (wr ? 0 : R);
            for (int k = 1; k <= last; k++) begin
                if (k == 1)               check_bus("latch", 3'b000, 1'b0, 1'b0, 2'b00);
                else if (k <= 1 + P)      check_bus("setup", sel, 1'b0, 1'b0, 2'b00);
                else if (k <= 1 + 2 * P)  check_bus("enable", sel, 1'b1, 1'b0, 2'b00);
                else                      check_bus("rdwait", 3'b000, 1'b0, 1'b0, 2'b00);
                if (k >= 2 && k <= 1 + 2 * P) begin
                    chk("phase_paddr", Paddr_hclk, addr);
                    chk("phase_pwrite", {31'd0, Pwrite_hclk}, {31'd0, wr});
                end
                Prdata_hclk = (k == last && !wr) ? rdata : $urandom;
                step();
                Hwdata = $urandom;
            end
            check_bus("done", 3'b000, 1'b0, 1'b1, 2'b00);
            if (wr) exp_pwdata = wdata;
            else    exp_hrdata = rdata;
        end
        check_held("end");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            Htrans = 2'($urandom_range(0, 2));
            Hreadyin = (Htrans == 2'b10) ? 1'b0 : 1'($urandom);
            Haddr = {6'd32, 26'($urandom)};
            Hwrite = 1'($urandom);
            step();
            check_bus("idle", 3'b000, 1'b0, 1'b1, 2'b00);
            check_held("idle");
        end
    endtask

    task automatic check_reset(input string tag);
        check_bus(tag, 3'b000, 1'b0, 1'b1, 2'b00);
        chk({tag, "_hrdata"}, Hrdata, 32'd0);
        chk({tag, "_paddr"}, Paddr_hclk, 32'd0);
        chk({tag, "_pwdata"}, Pwdata_hclk, 32'd0);
        chk({tag, "_pwrite"}, {31'd0, Pwrite_hclk}, 32'd0);
    endtask

    initial begin
        Hresetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b0; Htrans = 2'b00;
        Haddr = '0; Hwdata = '0; Prdata_hclk = '0;
        exp_hrdata = '0; exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
        step();
        step();
        check_reset("reset");
        Hresetn = 1'b1;
        idle(2);

        xfer(32'h8000_0010, 1'b1, 32'hA5A5_0001, 32'h0);
        idle(1);
        xfer(32'h8400_0004, 1'b0, 32'h0, 32'h1234_5678);
        idle(1);

        Htrans = 2'b01; Haddr = 32'h8000_0000; Hreadyin = 1'b1; Hwrite = 1'b1;
        step();
        check_bus("busy", 3'b000, 1'b0, 1'b1, 2'b00);
        Htrans = 2'b00; Haddr = 32'h8800_0000;
        step();
        check_bus("htrans_idle", 3'b000, 1'b0, 1'b1, 2'b00);
        check_held("htrans_idle");

        xfer(32'h9000_0000, 1'b1, 32'hCAFE_0001, 32'h0);
        idle(1);
        xfer(32'h9000_0000, 1'b0, 32'h0, 32'hDEAD_BEEF);
        idle(1);

        xfer(32'h8000_0020, 1'b1, 32'h1111_2222, 32'h0);
        xfer(32'h8800_0000, 1'b1, 32'h3333_4444, 32'h0);
        xfer(32'h8400_0100, 1'b0, 32'h0, 32'h5555_6666);
        idle(2);

        for (int t = 0; t < 24; t++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 3);
            if (r < 3) a = {6'(32 + r), 26'($urandom)};
            else       a = {1'b0, 31'($urandom)};
            xfer(a, 1'($urandom), $urandom, $urandom);
            idle($urandom_range(0, 2));
        end

        xfer(32'h8400_0200, 1'b0, 32'h0, 32'h0BAD_F00D);
        idle(1);
        Haddr = 32'h8000_0100; Hwrite = 1'b1; Htrans = 2'b10; Hreadyin = 1'b1;
        step();
        Htrans = 2'b00; Hwdata = 32'h7777_8888;
        for (int k = 1; k < 7; k++) step();
        check_bus("pre_reset_enable", 3'b001, 1'b1, 1'b0, 2'b00);
        #2;
        Hresetn = 1'b0;
        #1;
        check_reset("async_reset");
        step();
        Hresetn = 1'b1;
        exp_hrdata = '0; exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
